// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter shared definitions: FSM encodings,
// one-hot grant constants and the response bundle.
package wb_arbiter_pkg;

  localparam int unsigned DAT_WIDTH_DEF = 64;

  localparam logic [2:0] ARB_IDLE = 3'd0;
  localparam logic [2:0] ARB_G0   = 3'd1;
  localparam logic [2:0] ARB_G1   = 3'd2;
  localparam logic [2:0] ARB_REL  = 3'd3;
  localparam logic [2:0] ARB_TERR = 3'd4;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  typedef struct packed {
    logic ack;
    logic err;
  } wb_rsp_t;

  function automatic logic [1:0] state_gnt(
    input logic [2:0] st
  );
    logic [1:0] g;
    g = GNT_NONE;
    if (st == ARB_G0) g = GNT_M0;
    if (st == ARB_G1) g = GNT_M1;
    return g;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundled bus of the two-master wb_arbiter.
// Signal names are from the arbiter's point of view.
interface wb_arbiter_if #(
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned DAT_WIDTH = 64
);

  logic [ADR_WIDTH-1:0] m0_adr_i;
  logic [ADR_WIDTH-1:0] m1_adr_i;
  logic [DAT_WIDTH-1:0] m0_dat_i;
  logic [DAT_WIDTH-1:0] m1_dat_i;
  logic                 m0_we_i;
  logic                 m1_we_i;
  logic                 m0_stb_i;
  logic                 m1_stb_i;
  logic [DAT_WIDTH-1:0] m0_dat_o;
  logic [DAT_WIDTH-1:0] m1_dat_o;
  logic                 m0_ack_o;
  logic                 m1_ack_o;
  logic                 m0_err_o;
  logic                 m1_err_o;

  logic [ADR_WIDTH-1:0] s_adr_o;
  logic [DAT_WIDTH-1:0] s_dat_o;
  logic                 s_we_o;
  logic                 s_stb_o;
  logic [DAT_WIDTH-1:0] s_dat_i;
  logic                 s_ack_i;
  logic                 s_err_i;

  logic [1:0]           gnt_o;

  modport slave (
    input  m0_adr_i, m1_adr_i,
    input  m0_dat_i, m1_dat_i,
    input  m0_we_i,  m1_we_i,
    input  m0_stb_i, m1_stb_i,
    output m0_dat_o, m1_dat_o,
    output m0_ack_o, m1_ack_o,
    output m0_err_o, m1_err_o,
    output s_adr_o,  s_dat_o,
    output s_we_o,   s_stb_o,
    input  s_dat_i,  s_ack_i,
    input  s_err_i,
    output gnt_o
  );

  modport master (
    output m0_adr_i, m1_adr_i,
    output m0_dat_i, m1_dat_i,
    output m0_we_i,  m1_we_i,
    output m0_stb_i, m1_stb_i,
    input  m0_dat_o, m1_dat_o,
    input  m0_ack_o, m1_ack_o,
    input  m0_err_o, m1_err_o,
    input  s_adr_o,  s_dat_o,
    input  s_we_o,   s_stb_o,
    output s_dat_i,  s_ack_i,
    output s_err_i,
    input  gnt_o
  );

endinterface

// File: rtl/wb_arb_rr2.sv
// Two-way round-robin pick: on a tie the master
// that did not win last time gets the one-hot grant.
module wb_arb_rr2
  import wb_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    unique case (1'b1)
      (req_i == 2'b11): gnt_o = last_i ? GNT_M0 : GNT_M1;
      (req_i == 2'b01): gnt_o = GNT_M0;
      (req_i == 2'b10): gnt_o = GNT_M1;
      default:          gnt_o = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter, round-robin, one idle cycle per grant.
// Optional slave-hang timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned DAT_WIDTH = DAT_WIDTH_DEF,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wb_arbiter_if.slave bus
);

  logic [2:0] state_q, state_d;
  logic       last_q,  last_d;
  logic [1:0] pick;
  logic       granted;
  logic       own_stb;
  logic       to_hit;
  wb_rsp_t    rsp;

  logic [ADR_WIDTH-1:0] adr_mux;
  logic [DAT_WIDTH-1:0] dat_mux;
  logic                 we_mux;

  wb_arb_rr2 u_rr (
    .req_i  ({bus.m1_stb_i, bus.m0_stb_i}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign granted = (state_q == ARB_G0) ||
                   (state_q == ARB_G1);

  // last_q names the owner while a grant or TERR is active
  assign own_stb = last_q ? bus.m1_stb_i
                          : bus.m0_stb_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign to_hit = granted &&
                  (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_IDLE) begin
      cnt_d = '0;
    end else if (granted) begin
      if (bus.s_ack_i || bus.s_err_i)
        cnt_d = '0;
      else if (!to_hit)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick == GNT_M0) begin
          state_d = ARB_G0;
          last_d  = 1'b0;
        end else if (pick == GNT_M1) begin
          state_d = ARB_G1;
          last_d  = 1'b1;
        end
      end
      ARB_G0, ARB_G1: begin
        if (!own_stb)
          state_d = ARB_REL;
        else if (to_hit)
          state_d = ARB_TERR;
      end
      ARB_TERR: begin
        if (!own_stb) state_d = ARB_REL;
      end
      ARB_REL:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    adr_mux = last_q ? bus.m1_adr_i
                     : bus.m0_adr_i;
    dat_mux = last_q ? bus.m1_dat_i
                     : bus.m0_dat_i;
    we_mux  = last_q ? bus.m1_we_i
                     : bus.m0_we_i;
  end

  assign bus.s_adr_o = granted ? adr_mux : '0;
  assign bus.s_dat_o = granted ? dat_mux : '0;
  assign bus.s_we_o  = granted && we_mux;
  assign bus.s_stb_o = granted && own_stb &&
                       !to_hit;

  // responses outside a grant never reach a master
  always_comb begin
    rsp.ack = granted && !to_hit &&
              bus.s_ack_i;
    rsp.err = (granted &&
               (to_hit || bus.s_err_i)) ||
              (state_q == ARB_TERR);
  end

  assign bus.m0_ack_o = rsp.ack && !last_q;
  assign bus.m1_ack_o = rsp.ack &&  last_q;
  assign bus.m0_err_o = rsp.err && !last_q;
  assign bus.m1_err_o = rsp.err &&  last_q;

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;

  assign bus.gnt_o = state_gnt(state_q);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table,
// corner sequences and a randomized reference model.
module tb_wb_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   force_ack = 1'b0;
  bit   hang = 1'b0;
  int   checks = 0;
  int   failures = 0;

  wb_arbiter_if #(.ADR_WIDTH(16), .DAT_WIDTH(64)) bus ();

  wb_arbiter #(
    .ADR_WIDTH (16),
    .DAT_WIDTH (64),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rom(input logic [15:0] a);
    if (a == 16'h0000) return 64'h0287800010001018;
    return {32'hA5A55A5A, 16'h0000, a};
  endfunction

  // ROM slave: reads ack in the same cycle, writes get err
  always_comb begin
    bus.s_dat_i = rom(bus.s_adr_o);
    bus.s_ack_i = force_ack ||
                  (bus.s_stb_o && !bus.s_we_o && !hang);
    bus.s_err_i = bus.s_stb_o && bus.s_we_o && !hang;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit s0, input bit s1,
                       input bit w0, input bit w1,
                       input logic [15:0] a0,
                       input logic [15:0] a1,
                       input logic [63:0] d0,
                       input logic [63:0] d1);
    bus.m0_stb_i = s0;
    bus.m1_stb_i = s1;
    bus.m0_we_i  = w0;
    bus.m1_we_i  = w1;
    bus.m0_adr_i = a0;
    bus.m1_adr_i = a1;
    bus.m0_dat_i = d0;
    bus.m1_dat_i = d1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 16'h0, 16'h0, 64'h0, 64'h0);
    force_ack = 1'b0;
    hang = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_outs",
        {58'h0, bus.gnt_o, bus.s_stb_o, bus.s_we_o,
         bus.m0_ack_o, bus.m1_ack_o},
        64'h0);
    chk("reset_adr", {48'h0, bus.s_adr_o}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         s0, s1, w0, w1, fa;
    logic [1:0] gnt;
    bit         sstb, ack0, ack1, err0, err1;
    logic [63:0] dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(
    input bit r, input bit s0, input bit s1,
    input bit w0, input bit w1, input bit fa,
    input logic [1:0] g, input bit ss,
    input bit a0, input bit a1,
    input bit e0, input bit e1,
    input logic [63:0] d);
    vec_t v;
    v.rst = r; v.s0 = s0; v.s1 = s1;
    v.w0 = w0; v.w1 = w1; v.fa = fa;
    v.gnt = g; v.sstb = ss;
    v.ack0 = a0; v.ack1 = a1;
    v.err0 = e0; v.err1 = e1;
    v.dat = d;
    return v;
  endfunction

  // reference model state: owner -1 = nobody
  int m_own;
  bit m_rel;
  int m_last;

  task automatic model_step(input bit s0, input bit s1);
    bit want[2];
    want[0] = s0;
    want[1] = s1;
    if (m_rel) begin
      m_rel = 1'b0;
    end else if (m_own >= 0) begin
      if (!want[m_own]) begin
        m_own = -1;
        m_rel = 1'b1;
      end
    end else if (s0 || s1) begin
      if (s0 && s1) m_own = 1 - m_last;
      else          m_own = s0 ? 0 : 1;
      m_last = m_own;
    end
  endtask

  initial begin
    logic [63:0] r0, r10;
    r0  = rom(16'h0000);
    r10 = rom(16'h0010);

    // r  s0 s1 w0 w1 fa  gnt  stb a0 a1 e0 e1 dat
    vecs.push_back(mkv(1,1,0,0,0,0,2'b01,1,1,0,0,0,r0));
    vecs.push_back(mkv(0,1,0,0,0,0,2'b01,1,1,0,0,0,r0));
    vecs.push_back(mkv(0,0,0,0,0,0,2'b00,0,0,0,0,0,r0));
    vecs.push_back(mkv(0,0,0,0,0,0,2'b00,0,0,0,0,0,r0));
    vecs.push_back(mkv(1,1,1,0,0,0,2'b01,1,1,0,0,0,r0));
    vecs.push_back(mkv(0,0,1,0,0,0,2'b00,0,0,0,0,0,r0));
    vecs.push_back(mkv(0,0,1,0,0,0,2'b00,0,0,0,0,0,r0));
    vecs.push_back(mkv(0,0,1,0,0,0,2'b10,1,0,1,0,0,r10));
    vecs.push_back(mkv(0,0,0,0,0,0,2'b00,0,0,0,0,0,r0));
    vecs.push_back(mkv(1,0,1,0,1,0,2'b10,1,0,0,0,1,r10));
    vecs.push_back(mkv(0,0,0,0,0,1,2'b00,0,0,0,0,0,r0));
    vecs.push_back(mkv(0,0,0,0,0,1,2'b00,0,0,0,0,0,r0));
    vecs.push_back(mkv(0,0,1,0,0,0,2'b10,1,0,1,0,0,r10));

    drive(0, 0, 0, 0, 16'h0, 16'h0, 64'h0, 64'h0);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].s0, vecs[i].s1,
            vecs[i].w0, vecs[i].w1,
            16'h0000, 16'h0010,
            64'h1111, 64'h2222);
      force_ack = vecs[i].fa;
      step();
      chk($sformatf("v%0d_gnt", i),
          {62'h0, bus.gnt_o}, {62'h0, vecs[i].gnt});
      chk($sformatf("v%0d_stb", i),
          {63'h0, bus.s_stb_o}, {63'h0, vecs[i].sstb});
      chk($sformatf("v%0d_rsp", i),
          {60'h0, bus.m0_ack_o, bus.m1_ack_o,
           bus.m0_err_o, bus.m1_err_o},
          {60'h0, vecs[i].ack0, vecs[i].ack1,
           vecs[i].err0, vecs[i].err1});
      chk($sformatf("v%0d_dat0", i),
          bus.m0_dat_o, vecs[i].dat);
      chk($sformatf("v%0d_dat1", i),
          bus.m1_dat_o, vecs[i].dat);
    end

    // fairness with both masters always requesting
    begin
      int order[$];
      int since_drop;
      int cyc;
      logic [1:0] prev_g;
      do_reset();
      drive(1, 1, 0, 0, 16'h0004, 16'h0008,
            64'h0, 64'h0);
      since_drop = -1;
      prev_g = 2'b00;
      cyc = 0;
      while (order.size() < 6 && cyc < 100) begin
        step();
        cyc++;
        if (since_drop >= 0) since_drop++;
        if (prev_g == 2'b00 && bus.gnt_o != 2'b00) begin
          order.push_back(bus.gnt_o == 2'b01 ? 0 : 1);
          if (since_drop >= 0)
            chk("rr_wait",
                {63'h0, since_drop > 3}, 64'h0);
          since_drop = -1;
        end
        prev_g = bus.gnt_o;
        bus.m0_stb_i = !bus.m0_ack_o;
        bus.m1_stb_i = !bus.m1_ack_o;
        if (bus.m0_ack_o || bus.m1_ack_o)
          since_drop = 0;
      end
      chk("rr_count", order.size(), 6);
      for (int i = 0; i < order.size(); i++)
        chk($sformatf("rr_order%0d", i), order[i], i % 2);
    end

    // slave that never responds
    do_reset();
    hang = 1'b1;
    drive(1, 0, 0, 0, 16'h0000, 16'h0000,
          64'h0, 64'h0);
`ifdef WB_ARB_TIMEOUT_EN
    begin
      int bad;
      bad = 0;
      for (int k = 1; k <= 8; k++) begin
        step();
        if (bus.m0_err_o || !bus.s_stb_o) bad++;
      end
      chk("to_before", bad, 0);
      step();
      chk("to_hit",
          {62'h0, bus.m0_err_o, bus.s_stb_o}, 64'h2);
      step();
      chk("to_hold",
          {61'h0, bus.m0_err_o, bus.s_stb_o,
           bus.m1_err_o}, 64'h4);
      bus.m0_stb_i = 1'b0;
      step();
      chk("to_rel",
          {62'h0, bus.m0_err_o, bus.gnt_o == 2'b00},
          64'h1);
    end
`else
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 120; k++) begin
        step();
        if (bus.gnt_o != 2'b01 || !bus.s_stb_o ||
            bus.m0_err_o) bad++;
      end
      chk("hang_hold", bad, 0);
      bus.m0_stb_i = 1'b0;
      step();
      chk("hang_rel", {62'h0, bus.gnt_o}, 64'h0);
    end
`endif
    hang = 1'b0;

    // asynchronous reset in the middle of a G1 phase
    do_reset();
    bus.m1_stb_i = 1'b1;
    step();
    chk("ar_pre",
        {61'h0, bus.gnt_o, bus.m1_ack_o}, 64'h5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_drop",
        {60'h0, bus.gnt_o, bus.s_stb_o, bus.m1_ack_o},
        64'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.m0_stb_i = 1'b1;
    step();
    chk("ar_tie", {62'h0, bus.gnt_o}, 64'h1);

    // randomized traffic against the reference model
    do_reset();
    m_own = -1;
    m_rel = 1'b0;
    m_last = 1;
    for (int c = 0; c < 400; c++) begin
      bit s[2];
      bit w[2];
      logic [15:0] a[2];
      logic [63:0] d[2];
      bit fa, es, sack, serr;
      int o;
      for (int k = 0; k < 2; k++) begin
        s[k] = ($urandom_range(9) < 7);
        w[k] = ($urandom_range(3) == 0);
        a[k] = 16'($urandom);
        d[k] = {$urandom, $urandom};
      end
      fa = ($urandom_range(9) == 0);
      drive(s[0], s[1], w[0], w[1],
            a[0], a[1], d[0], d[1]);
      force_ack = fa;
      @(posedge clk);
      model_step(s[0], s[1]);
      @(negedge clk);
      o = m_own;
      es = (o >= 0) && s[o];
      sack = fa || (es && !w[o]);
      serr = es && w[o];
      chk("rnd_gnt", {62'h0, bus.gnt_o},
          (o < 0) ? 64'h0 : (64'h1 << o));
      chk("rnd_stb", {63'h0, bus.s_stb_o}, {63'h0, es});
      chk("rnd_adr", {48'h0, bus.s_adr_o},
          (o < 0) ? 64'h0 : {48'h0, a[o]});
      chk("rnd_wdat", bus.s_dat_o,
          (o < 0) ? 64'h0 : d[o]);
      chk("rnd_we", {63'h0, bus.s_we_o},
          (o < 0) ? 64'h0 : {63'h0, w[o]});
      chk("rnd_rsp",
          {60'h0, bus.m0_ack_o, bus.m1_ack_o,
           bus.m0_err_o, bus.m1_err_o},
          {60'h0, (o == 0) && sack, (o == 1) && sack,
           (o == 0) && serr, (o == 1) && serr});
      chk("rnd_rdat", bus.m1_dat_o,
          rom((o < 0) ? 16'h0 : a[o]));
    end
    force_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter that shares a single slave (boot ROM, or any slave using the common Wishbone slave port) between the instruction-fetch master (m0) and the load/store master (m1).
- Grants are round-robin.
- A grant is held until the granted master ends its phase by dropping stb.
- One forced idle cycle follows every grant so the slave sees stb low and returns to its idle state.

Parameters:
- ADR_WIDTH, 16, address bus width.
- DAT_WIDTH, `DAT_WIDTH from config.v (64), data bus width.
- TIMEOUT, 64, cycles without ack/err before a forced error (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- m0_adr_i, m1_adr_i  in  ADR_WIDTH  master addresses
- m0_dat_i, m1_dat_i  in  DAT_WIDTH  master write data
- m0_we_i, m1_we_i  in  1  write enables
- m0_stb_i, m1_stb_i  in  1  requests/strobes
- m0_dat_o, m1_dat_o  out  DAT_WIDTH  read data (slave data routed to both)
- m0_ack_o, m1_ack_o  out  1  acknowledge, granted master only
- m0_err_o, m1_err_o  out  1  error, granted master only
- s_adr_o  out  ADR_WIDTH  slave address
- s_dat_o  out  DAT_WIDTH  slave write data
- s_we_o  out  1  slave write enable
- s_stb_o  out  1  slave strobe
- s_dat_i  in  DAT_WIDTH  slave read data
- s_ack_i  in  1  slave acknowledge
- s_err_i  in  1  slave error
- gnt_o  out  2  one-hot current grant (debug/visibility)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, last=1 (m0 wins the first tie), gnt_o=0.
- During reset, s_stb_o, s_we_o, s_adr_o, s_dat_o, all ack_o and all err_o are 0.
- States:
  - IDLE: no grant.
  - G0 / G1: m0 / m1 owns the slave.
  - REL: one idle cycle after a grant.
  - TERR: only with the optional feature.
- IDLE transitions:
  - Only m0_stb_i high -> G0. Only m1_stb_i high -> G1.
  - Both high -> grant the master that is not `last`.
  - Neither high -> stay in IDLE.
  - Arbitration latency: request seen in cycle N, slave strobed in cycle N+1.
- On entering Gx: last <= x.
- In Gx, the granted master's adr/dat/we/stb pass combinationally to the slave. s_ack_i and s_err_i are routed to mx only; the other master sees ack=0, err=0.
- Gx -> REL when mx_stb_i=0, sampled at the clock edge.
- Held grant: one Gx may cover any number of ack'd beats as long as stb stays high.
- REL: all s_* outputs 0. Always goes to IDLE on the next cycle. Requests arriving during REL are served from IDLE.
- Ungranted master:
  - Stb is ignored; ack/err stay 0 and it waits (no drop, no error).
  - Requests are level-based; nothing is queued.
- s_ack_i or s_err_i while in IDLE or REL: ignored, not routed.
- Fairness: with both masters continuously requesting and each ending its phase after one ack, grants alternate m0, m1, m0, ...
- Starvation bound: one competing grant plus REL plus IDLE.
- gnt_o: 2'b01 in G0, 2'b10 in G1, else 0.
- m0_dat_o and m1_dat_o both equal s_dat_i at all times.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entering Gx or on any s_ack_i/s_err_i, and increments in Gx otherwise.
  - When the counter reaches TIMEOUT: state goes to TERR, s_stb_o is forced 0, and mx_err_o=1 is held until mx_stb_i drops. Then TERR -> REL.
  - The counter resets to 0 asynchronously.
- Not defined: no counter and no TERR; a hung slave holds the grant indefinitely.

Decomposition:
- Shared package/include, next to config.v:
  - State encodings: ARB_IDLE, ARB_G0, ARB_G1, ARB_REL, ARB_TERR.
  - Grant one-hot constants.
- Natural sub-module: wb_arb_rr2, a 2-way round-robin pick taking requests and `last` and producing a one-hot grant (combinational). Mux and FSM stay in wb_arbiter.

Test Plan:
1. m0 reads 0x0000 alone (stb held 1 cycle past ack) -> s_stb_o rises in cycle +1 with s_adr_o=0x0000; m0_ack_o=1; m0_dat_o=0x0287800010001018; m1_ack_o=0; one REL cycle follows.
2. m0 and m1 raise stb in the same cycle out of reset -> G0 first; after m0 drops stb, REL then IDLE then G1; gnt_o sequence 01,00,00,10.
3. Both request continuously for 6 transactions -> grant order m0,m1,m0,m1,m0,m1; each master waits at most 3 cycles after its rival's stb drops.
4. m1 writes (we=1) to the ROM slave -> m1_err_o=1, m1_ack_o=0; m0_err_o stays 0; the slave returns to idle after REL.
5. With WB_ARB_TIMEOUT_EN and TIMEOUT=8, a slave that never acks -> m0_err_o asserts in the 9th cycle of G0 and s_stb_o goes 0. Without the macro, the grant holds for 100+ cycles.
6. rst_i pulsed mid-G1 (asynchronous, between edges) -> s_stb_o and m1_ack_o drop immediately; after release the first tie goes to m0.
